// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file constants, state encodings and small helpers.
package regfile_write_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    // Registers cleared at start-up; register 0 is hardwired and skipped.
    localparam logic [REG_ADDR_W-1:0] FIRST_INIT_REG = 5'd1;
    localparam logic [REG_ADDR_W-1:0] LAST_INIT_REG  = 5'd31;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

    // Writes to register 0 are accepted but never reach the register file.
    function automatic logic is_writable(input logic [REG_ADDR_W-1:0] addr);
        return addr != {REG_ADDR_W{1'b0}};
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant logic with its priority flop.
module rr_arbiter2
    import regfile_write_arbiter_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic valid_a_i,
    input  logic valid_b_i,
    output logic ready_a_o,
    output logic ready_b_o,
    output logic fire_a_o,
    output logic fire_b_o
);

    prio_e prio_q;
    prio_e prio_d;

    // Readies: an uncontested requester always wins, contention goes to prio.
    always_comb begin
        ready_a_o = 1'b0;
        ready_b_o = 1'b0;
        if (en_i) begin
            ready_a_o = !valid_b_i || (prio_q == PRIO_A);
            ready_b_o = !valid_a_i || (prio_q == PRIO_B);
        end else begin
            ready_a_o = 1'b0;
            ready_b_o = 1'b0;
        end
        fire_a_o = valid_a_i && ready_a_o;
        fire_b_o = valid_b_i && ready_b_o;
    end

    // Next priority: point away from whoever just completed a handshake.
    always_comb begin
        prio_d = prio_q;
        if (fire_a_o) begin
            prio_d = PRIO_B;
        end else if (fire_b_o) begin
            prio_d = PRIO_A;
        end else begin
            prio_d = prio_q;
        end
    end

    // Priority flop, starts favouring requester A.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prio_q <= PRIO_A;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write port: clears registers 1..31 after reset, then
// arbitrates two write requesters round-robin onto registered write outputs.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter logic [REG_DATA_W-1:0] INIT_VALUE = 32'd0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  ReqA_Valid,
    input  logic [REG_ADDR_W-1:0] ReqA_Addr,
    input  logic [REG_DATA_W-1:0] ReqA_Data,
    output logic                  ReqA_Ready,
    input  logic                  ReqB_Valid,
    input  logic [REG_ADDR_W-1:0] ReqB_Addr,
    input  logic [REG_DATA_W-1:0] ReqB_Data,
    output logic                  ReqB_Ready,
    output logic [REG_ADDR_W-1:0] WriteRegister,
    output logic [REG_DATA_W-1:0] WriteData,
    output logic                  RegWrite,
    output logic                  InitDone
);

    state_e                  state_q, state_d;
    logic [REG_ADDR_W-1:0]   cnt_q, cnt_d;
    logic [REG_ADDR_W-1:0]   wreg_q, wreg_d;
    logic [REG_DATA_W-1:0]   wdata_q, wdata_d;
    logic                    regwrite_q, regwrite_d;
    logic                    initdone_q, initdone_d;
    logic                    fire_a_s, fire_b_s;

    rr_arbiter2 u_arb (
        .clk_i     (Clk),
        .reset_i   (Reset),
        .en_i      (state_q == ST_RUN),
        .valid_a_i (ReqA_Valid),
        .valid_b_i (ReqB_Valid),
        .ready_a_o (ReqA_Ready),
        .ready_b_o (ReqB_Ready),
        .fire_a_o  (fire_a_s),
        .fire_b_o  (fire_b_s)
    );

    // State and output registers; reset abandons any in-flight write.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_INIT;
            cnt_q      <= FIRST_INIT_REG;
            wreg_q     <= 5'd0;
            wdata_q    <= 32'd0;
            regwrite_q <= 1'b0;
            initdone_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            regwrite_q <= regwrite_d;
            initdone_q <= initdone_d;
        end
    end

    // Next state: leave INIT on the edge that issues the last init write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == LAST_INIT_REG) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // Outputs: sweep init writes, then forward the granted request.
    always_comb begin
        cnt_d      = cnt_q;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        regwrite_d = 1'b0;
        initdone_d = initdone_q;
        case (state_q)
            ST_INIT: begin
                regwrite_d = 1'b1;
                wreg_d     = cnt_q;
                wdata_d    = INIT_VALUE;
                cnt_d      = cnt_q + 5'd1;
                if (cnt_q == LAST_INIT_REG) begin
                    initdone_d = 1'b1;
                end else begin
                    initdone_d = initdone_q;
                end
            end
            ST_RUN: begin
                if (fire_a_s) begin
                    wreg_d     = ReqA_Addr;
                    wdata_d    = ReqA_Data;
                    regwrite_d = is_writable(ReqA_Addr);
                end else if (fire_b_s) begin
                    wreg_d     = ReqB_Addr;
                    wdata_d    = ReqB_Data;
                    regwrite_d = is_writable(ReqB_Addr);
                end else begin
                    regwrite_d = 1'b0;
                end
            end
            default: begin
                regwrite_d = 1'b0;
            end
        endcase
    end

    assign WriteRegister = wreg_q;
    assign WriteData     = wdata_q;
    assign RegWrite      = regwrite_q;
    assign InitDone      = initdone_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a simple register-file model.
module tb_regfile_write_arbiter;

    logic        Clk;
    logic        Reset;
    logic        ReqA_Valid, ReqB_Valid;
    logic [4:0]  ReqA_Addr, ReqB_Addr;
    logic [31:0] ReqA_Data, ReqB_Data;
    logic        ReqA_Ready, ReqB_Ready;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic        InitDone;

    int tests_run;
    int tests_failed;

    logic [31:0] rf [0:31];

    regfile_write_arbiter #(.INIT_VALUE(32'd0)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .ReqA_Valid    (ReqA_Valid),
        .ReqA_Addr     (ReqA_Addr),
        .ReqA_Data     (ReqA_Data),
        .ReqA_Ready    (ReqA_Ready),
        .ReqB_Valid    (ReqB_Valid),
        .ReqB_Addr     (ReqB_Addr),
        .ReqB_Data     (ReqB_Data),
        .ReqB_Ready    (ReqB_Ready),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .InitDone      (InitDone)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Register file model: commits the presented write on the following edge.
    always @(posedge Clk) begin
        if (RegWrite) rf[WriteRegister] <= WriteData;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rf[0]      = 32'd0;
        Reset      = 1'b1;
        ReqA_Valid = 1'b0; ReqA_Addr = 5'd0; ReqA_Data = 32'd0;
        ReqB_Valid = 1'b0; ReqB_Addr = 5'd0; ReqB_Data = 32'd0;

        // Reset for two cycles
        tick();
        tick();
        chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("rst_wreg",     {27'd0, WriteRegister}, 32'd0);
        chk("rst_wdata",    WriteData, 32'd0);
        chk("rst_initdone", {31'd0, InitDone}, 32'd0);
        chk("rst_ready_a",  {31'd0, ReqA_Ready}, 32'd0);
        chk("rst_ready_b",  {31'd0, ReqB_Ready}, 32'd0);

        // Initialization sweep with both requesters asking (must be held off)
        Reset      = 1'b0;
        ReqA_Valid = 1'b1; ReqA_Addr = 5'd9; ReqA_Data = 32'hDEAD;
        ReqB_Valid = 1'b1; ReqB_Addr = 5'd9; ReqB_Data = 32'hBEEF;
        for (int i = 1; i <= 31; i++) begin
            tick();
            chk("init_regwrite", {31'd0, RegWrite}, 32'd1);
            chk("init_wreg",     {27'd0, WriteRegister}, i);
            chk("init_wdata",    WriteData, 32'd0);
            chk("init_done",     {31'd0, InitDone}, (i == 31) ? 32'd1 : 32'd0);
            if (i < 31) begin
                chk("init_ready_a", {31'd0, ReqA_Ready}, 32'd0);
                chk("init_ready_b", {31'd0, ReqB_Ready}, 32'd0);
            end
        end
        ReqA_Valid = 1'b0;
        ReqB_Valid = 1'b0;
        tick();
        chk("idle_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("idle_wreg_hold", {27'd0, WriteRegister}, 32'd31);
        chk("rf5_after_init", rf[5], 32'd0);
        chk("rf31_after_init", rf[31], 32'd0);

        // Single write from A
        ReqA_Valid = 1'b1; ReqA_Addr = 5'd2; ReqA_Data = 32'd42;
        #1;
        chk("a_only_ready", {31'd0, ReqA_Ready}, 32'd1);
        tick();
        ReqA_Valid = 1'b0;
        chk("a_only_regwrite", {31'd0, RegWrite}, 32'd1);
        chk("a_only_wreg",     {27'd0, WriteRegister}, 32'd2);
        chk("a_only_wdata",    WriteData, 32'd42);
        tick();
        chk("a_only_rf2", rf[2], 32'd42);
        chk("a_only_idle", {31'd0, RegWrite}, 32'd0);

        // Single write from B hands priority back to A
        ReqB_Valid = 1'b1; ReqB_Addr = 5'd6; ReqB_Data = 32'h55;
        #1;
        chk("b_only_ready", {31'd0, ReqB_Ready}, 32'd1);
        tick();
        ReqB_Valid = 1'b0;
        chk("b_only_wreg",  {27'd0, WriteRegister}, 32'd6);
        chk("b_only_wdata", WriteData, 32'h55);

        // Contention: grants alternate A,B,A,B
        ReqA_Valid = 1'b1; ReqA_Addr = 5'd3; ReqA_Data = 32'd7;
        ReqB_Valid = 1'b1; ReqB_Addr = 5'd4; ReqB_Data = 32'd9;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready_a", {31'd0, ReqA_Ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_ready_b", {31'd0, ReqB_Ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            chk("rr_regwrite", {31'd0, RegWrite}, 32'd1);
            chk("rr_wreg",  {27'd0, WriteRegister}, (k % 2 == 0) ? 32'd3 : 32'd4);
            chk("rr_wdata", WriteData, (k % 2 == 0) ? 32'd7 : 32'd9);
        end
        ReqA_Valid = 1'b0;
        ReqB_Valid = 1'b0;
        tick();
        chk("rr_rf3", rf[3], 32'd7);
        chk("rr_rf4", rf[4], 32'd9);

        // Same target register: A first, then B; B's value persists
        ReqA_Valid = 1'b1; ReqA_Addr = 5'd2; ReqA_Data = 32'd12;
        ReqB_Valid = 1'b1; ReqB_Addr = 5'd2; ReqB_Data = 32'd18;
        tick();
        ReqA_Valid = 1'b0;
        chk("same_first_wdata", WriteData, 32'd12);
        chk("same_first_we",    {31'd0, RegWrite}, 32'd1);
        tick();
        ReqB_Valid = 1'b0;
        chk("same_second_wdata", WriteData, 32'd18);
        chk("same_second_we",    {31'd0, RegWrite}, 32'd1);
        tick();
        chk("same_rf2", rf[2], 32'd18);

        // Write to register 0: handshake completes, no write enable
        ReqA_Valid = 1'b1; ReqA_Addr = 5'd0; ReqA_Data = 32'd3;
        #1;
        chk("zero_ready", {31'd0, ReqA_Ready}, 32'd1);
        tick();
        chk("zero_regwrite", {31'd0, RegWrite}, 32'd0);
        ReqA_Addr = 5'd10; ReqA_Data = 32'd1;
        ReqB_Valid = 1'b1; ReqB_Addr = 5'd7; ReqB_Data = 32'h77;
        #1;
        chk("zero_prio_a", {31'd0, ReqA_Ready}, 32'd0);
        chk("zero_prio_b", {31'd0, ReqB_Ready}, 32'd1);

        // Reset with B pending: request is abandoned, init restarts at 1
        ReqA_Valid = 1'b0;
        Reset      = 1'b1;
        tick();
        chk("mid_rst_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("mid_rst_wreg",     {27'd0, WriteRegister}, 32'd0);
        chk("mid_rst_wdata",    WriteData, 32'd0);
        chk("mid_rst_initdone", {31'd0, InitDone}, 32'd0);
        chk("mid_rst_ready_a",  {31'd0, ReqA_Ready}, 32'd0);
        chk("mid_rst_ready_b",  {31'd0, ReqB_Ready}, 32'd0);
        chk("rf0_never_written", rf[0], 32'd0);
        Reset      = 1'b0;
        ReqB_Valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i <= 7) begin
                chk("reinit_wreg", {27'd0, WriteRegister}, i);
                chk("reinit_we",   {31'd0, RegWrite}, 32'd1);
            end
        end
        chk("reinit_rf7", rf[7], 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
